// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - raw key inputs and conditioned key outputs bundle
interface key_conditioner_if;
    logic raw_b0;
    logic raw_b1;
    logic raw_enter;
    logic e0;
    logic e1;
    logic e2;
    logic key_busy;

    modport master (
        output raw_b0, raw_b1, raw_enter,
        input  e0, e1, e2, key_busy
    );

    modport slave (
        input  raw_b0, raw_b1, raw_enter,
        output e0, e1, e2, key_busy
    );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - synchronise, debounce and strobe the lock key inputs
module key_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    key_conditioner_if.slave kif
);
    typedef enum logic {IDLE, HELD} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Channel order everywhere: 0 = b0, 1 = b1, 2 = enter.
    logic [2:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [2:0]             synced;
    logic [2:0]             deb;
    logic [CNT_W-1:0]       cnt [3];

    state_t state;
    logic   e0_q;
    logic   e1_q;
    logic   e2_q;
    logic   busy_q;

    assign raw = {kif.raw_enter, kif.raw_b1, kif.raw_b0};

    // Synchroniser chains: the only place the asynchronous inputs are sampled.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                sync_q[i] <= '0;
            end else begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            end
        end
    end

    // Last synchroniser stage of each channel feeds its debouncer.
    always_comb begin
        synced = '0;
        for (int i = 0; i < 3; i++) begin
            synced[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Debouncers: level flips only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                cnt[i] <= '0;
                deb[i] <= 1'b0;
            end else if (synced[i] == deb[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt[i] <= '0;
                deb[i] <= synced[i];
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Enter FSM: one strobe per debounced press, code bits latched with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            e0_q   <= 1'b0;
            e1_q   <= 1'b0;
            e2_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            e2_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (deb[2]) begin
                        state  <= HELD;
                        e2_q   <= 1'b1;
                        e0_q   <= deb[0];
                        e1_q   <= deb[1];
                        busy_q <= 1'b1;
                    end
                end
                HELD: begin
                    if (!deb[2]) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign kif.e0       = e0_q;
    assign kif.e1       = e1_q;
    assign kif.e2       = e2_q;
    assign kif.key_busy = busy_q;
endmodule
